fp_special_pipe: RTL and testbench
==================================

FP_SPECIAL_PIPE -- requirements
Module: fp_special_pipe

Interface
REQ-001 The module SHALL expose parameter EXP_W, default 8, exponent field width.
REQ-002 The module SHALL expose parameter MAN_W, default 23, mantissa field width; derived W = 1+EXP_W+MAN_W (not overridable).
REQ-003 The module SHALL have these ports:
  clk  in  1  single clock, all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  in_valid  in  1  operand pair present
  in_ready  out  1  pipeline can accept operand pair
  op  in  1  0 = A+B, 1 = A-B
  a  in  W  operand A {sign, exp, mantissa}
  b  in  W  operand B {sign, exp, mantissa}
  out_valid  out  1  result present
  out_ready  in  1  downstream accepts result
  out_result  out  W  resolved result (all zeros when out_special=0)
  out_special  out  1  pair resolved here; 0 = normal adder path required
  out_invalid  out  1  IEEE invalid-operation flag

Function
REQ-004 Operand class: ZERO = exp 0, man 0; SUBNORMAL = exp 0, man != 0; INF = exp all-ones, man 0; NAN = exp all-ones, man != 0; NORMAL otherwise.
REQ-005 Signalling NaN: NAN with mantissa MSB = 0; quiet NaN: mantissa MSB = 1.
REQ-006 Effective B sign: sign_B XOR op, applied when B is not NAN; NaN signs are never altered.
REQ-007 Two register stages: S1 captures a, effective b and both classes; S2 captures result and flags; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-008 Transfer occurs when valid and ready are both high in the same cycle; out_result, out_special, out_invalid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S2 loads; in_ready = S1 empty or S2 loads (no combinational path from in_valid to in_ready).
REQ-010 Full throughput: one pair per cycle sustained when out_ready held high.
REQ-011 Resolution priority, first match wins:
  1 both NAN: larger payload (mantissa bits MAN_W-2..0) wins; equal payloads -> sign_A AND sign_B, A's exponent; quiet bit forced to 1.
  2 both ZERO: {sign_A AND sign_B_eff, zeros}.
  3 A ZERO or B NAN: B NAN -> B with quiet bit forced to 1; else B with effective sign.
  4 B ZERO or A NAN: A NAN -> A with quiet bit forced to 1; else A unchanged.
  5 A INF, B finite: A. A INF, B INF: same effective sign -> INF of that sign; opposite -> canonical NaN {1, all-ones, 1, zeros}.
  6 B INF: B with effective sign.
  7 otherwise out_special=0, out_result=0.
REQ-012 out_invalid=1 iff either input is a signalling NaN, or case 5 yields canonical NaN; else 0.
REQ-013 SUBNORMAL operands are treated as finite, never flushed.
REQ-014 All widths follow EXP_W/MAN_W; no hard-coded 8/23 constants.

Reset
REQ-015 While rst=1 at a clock edge: S1 and S2 valid cleared, out_valid=0, out_result=0, out_special=0, out_invalid=0; in_ready=1 from the first cycle after reset.
REQ-016 Reset mid-operation SHALL discard all in-flight pairs; no result from before reset appears afterward.
REQ-017 in_valid during reset is ignored.

Verification
REQ-018 Default params, a=0x7FC00001, b=0x7FC00002, op=0 -> 2 cycles later out_result=0x7FC00002, special=1, invalid=0.
REQ-019 a=0x7F800000, b=0x7F800000, op=1 -> out_result=0xFFC00000, special=1, invalid=1; same with op=0 -> 0x7F800000, invalid=0.
REQ-020 a=0x80000000, b=0x80000000, op=0 -> 0x80000000; a=0x00000000, b=0x80000000, op=0 -> 0x00000000.
REQ-021 a=0x7F800001 (sNaN), b=0x3F800000 -> 0x7FC00001, invalid=1; a=0x3F800000, b=0x40000000 -> special=0, result=0.
REQ-022 Backpressure: 4 back-to-back pairs, out_ready low 3 cycles -> in_ready low once S1 and S2 both full, output held stable, all 4 results delivered in order, none lost or duplicated.
REQ-023 Reset asserted 1 cycle after accepting a pair -> no out_valid follows; EXP_W=11, MAN_W=52: 0x7FF0000000000000 minus itself -> 0xFFF8000000000000, invalid=1.

Source files
------------

// File: rtl/fp_special_pipe.sv
// Two-stage valid/ready pipeline that resolves IEEE-754 add/sub operand pairs
// involving zeros, infinities and NaNs, flagging pairs that need the real adder.
module fp_special_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_special,
  output logic                 out_invalid
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QUIET_BIT = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] CANON_NAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    if (e == '0)      return (m == '0) ? CLS_ZERO : CLS_SUB;
    else if (&e)      return (m == '0) ? CLS_INF : CLS_NAN;
    else              return CLS_NORM;
  endfunction

  cls_t           w_clsA;
  cls_t           w_clsB;
  logic [W-1:0]   w_bEff;

  logic           r_s1Valid;
  logic [W-1:0]   r_s1A;
  logic [W-1:0]   r_s1B;
  cls_t           r_s1ClsA;
  cls_t           r_s1ClsB;

  logic           r_s2Valid;
  logic [W-1:0]   r_s2Result;
  logic           r_s2Special;
  logic           r_s2Invalid;

  logic           w_s1Load;
  logic           w_s2Load;

  logic           w_nanA, w_nanB, w_zeroA, w_zeroB, w_infA, w_infB;
  logic [MAN_W-2:0] w_payA, w_payB;
  logic [W-1:0]   w_res;
  logic           w_special;
  logic           w_canon;
  logic           w_invalid;

  // NaN signs are never touched by the subtract flip.
  assign w_clsA = classify(a);
  assign w_clsB = classify(b);
  assign w_bEff = (w_clsB == CLS_NAN) ? b : {b[W-1] ^ op, b[W-2:0]};

  assign w_s2Load = !r_s2Valid || out_ready;
  assign w_s1Load = !r_s1Valid || w_s2Load;
  assign in_ready = w_s1Load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1ClsA  <= CLS_ZERO;
      r_s1ClsB  <= CLS_ZERO;
    end else if (w_s1Load) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1A    <= a;
        r_s1B    <= w_bEff;
        r_s1ClsA <= w_clsA;
        r_s1ClsB <= w_clsB;
      end
    end
  end

  assign w_nanA  = (r_s1ClsA == CLS_NAN);
  assign w_nanB  = (r_s1ClsB == CLS_NAN);
  assign w_zeroA = (r_s1ClsA == CLS_ZERO);
  assign w_zeroB = (r_s1ClsB == CLS_ZERO);
  assign w_infA  = (r_s1ClsA == CLS_INF);
  assign w_infB  = (r_s1ClsB == CLS_INF);
  assign w_payA  = r_s1A[MAN_W-2:0];
  assign w_payB  = r_s1B[MAN_W-2:0];

  // Priority chain: first matching rule decides the result.
  always_comb begin
    w_res     = '0;
    w_special = 1'b1;
    w_canon   = 1'b0;
    if (w_nanA && w_nanB) begin
      if (w_payA > w_payB)      w_res = r_s1A | QUIET_BIT;
      else if (w_payB > w_payA) w_res = r_s1B | QUIET_BIT;
      else                      w_res = {r_s1A[W-1] & r_s1B[W-1], r_s1A[W-2:MAN_W], 1'b1, w_payA};
    end else if (w_zeroA && w_zeroB) begin
      w_res[W-1] = r_s1A[W-1] & r_s1B[W-1];
    end else if (w_zeroA || w_nanB) begin
      w_res = w_nanB ? (r_s1B | QUIET_BIT) : r_s1B;
    end else if (w_zeroB || w_nanA) begin
      w_res = w_nanA ? (r_s1A | QUIET_BIT) : r_s1A;
    end else if (w_infA) begin
      if (w_infB && (r_s1A[W-1] != r_s1B[W-1])) begin
        w_res   = CANON_NAN;
        w_canon = 1'b1;
      end else begin
        w_res = r_s1A;
      end
    end else if (w_infB) begin
      w_res = r_s1B;
    end else begin
      w_special = 1'b0;
    end
  end

  assign w_invalid = w_canon | (w_nanA & ~r_s1A[MAN_W-1]) | (w_nanB & ~r_s1B[MAN_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid   <= 1'b0;
      r_s2Result  <= '0;
      r_s2Special <= 1'b0;
      r_s2Invalid <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid   <= r_s1Valid;
      r_s2Result  <= r_s1Valid ? w_res : '0;
      r_s2Special <= r_s1Valid & w_special;
      r_s2Invalid <= r_s1Valid & w_invalid;
    end
  end

  assign out_valid   = r_s2Valid;
  assign out_result  = r_s2Result;
  assign out_special = r_s2Special;
  assign out_invalid = r_s2Invalid;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Randomized and directed bench for fp_special_pipe, scoreboarded against a
// flat reference model of the special-value resolution rules.
module tb_fp_special_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inValid, inReady, op, outValid, outReady;
  logic [31:0] a, b, outResult;
  logic        outSpecial, outInvalid;

  logic        inValid64, inReady64, op64, outValid64, outReady64;
  logic [63:0] a64, b64, outResult64;
  logic        outSpecial64, outInvalid64;

  int checks = 0;
  int errors = 0;
  logic [33:0] expQ[$];
  logic        prevRst = 1'b0;
  logic        held = 1'b0;
  logic [31:0] heldR;
  logic        heldS, heldI;

  fp_special_pipe dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .op(op),
    .a(a), .b(b), .out_valid(outValid), .out_ready(outReady),
    .out_result(outResult), .out_special(outSpecial), .out_invalid(outInvalid)
  );

  fp_special_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst), .in_valid(inValid64), .in_ready(inReady64), .op(op64),
    .a(a64), .b(b64), .out_valid(outValid64), .out_ready(outReady64),
    .out_result(outResult64), .out_special(outSpecial64), .out_invalid(outInvalid64)
  );

  // Reference: single-precision resolution computed directly from the rule list.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [31:0] yEff, r;
    logic spec, inv, nx, ny, zx, zy, ix, iy;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:0] == 0);
    zy = (y[30:0] == 0);
    yEff = ny ? y : {y[31] ^ sub, y[30:0]};
    inv = (nx && !x[22]) || (ny && !y[22]);
    spec = 1'b1;
    if (nx && ny) begin
      if (x[21:0] > y[21:0])      r = x | 32'h0040_0000;
      else if (y[21:0] > x[21:0]) r = y | 32'h0040_0000;
      else                        r = {x[31] & y[31], 8'hFF, 1'b1, x[21:0]};
    end else if (zx && zy)        r = {x[31] & yEff[31], 31'b0};
    else if (zx || ny)            r = ny ? (y | 32'h0040_0000) : yEff;
    else if (zy || nx)            r = nx ? (x | 32'h0040_0000) : x;
    else if (ix) begin
      if (iy && (x[31] != yEff[31])) begin
        r = 32'hFFC0_0000;
        inv = 1'b1;
      end else r = x;
    end else if (iy)              r = yEff;
    else begin
      r = 32'h0;
      spec = 1'b0;
    end
    return {r, spec, inv};
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] m;
    logic s;
    s = 1'($urandom_range(0, 1));
    m = $urandom & 32'h007F_FFFF;
    case ($urandom_range(0, 6))
      0:       return {s, 31'b0};
      1:       return {s, 8'h00, (m[22:0] == 0) ? 23'h1 : m[22:0]};
      2:       return {s, 8'hFF, 23'b0};
      3:       return {s, 8'hFF, 1'b1, m[21:0]};
      4:       return {s, 8'hFF, 1'b0, (m[21:0] == 0) ? 22'h1 : m[21:0]};
      5:       return {s, 8'hFF, 1'b0, 20'b0, m[1:0] | 2'b01};
      default: return {s, 8'(($urandom_range(1, 254))), m[22:0]};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actR, input logic actS, input logic actI,
                             input logic [31:0] expR, input logic expS, input logic expI);
    checks++;
    if (actR !== expR || actS !== expS || actI !== expI) begin
      errors++;
      $display("[TB] FAIL %s: got result=%h special=%b invalid=%b, expected result=%h special=%b invalid=%b",
               name, actR, actS, actI, expR, expS, expI);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                               input logic iop, input logic ordy, input logic irst);
    @(negedge clk);
    rst = irst;
    inValid = v;
    a = ia;
    b = ib;
    op = iop;
    outReady = ordy;
  endtask

  // Compare process: scoreboard, hold stability and post-reset state.
  always @(negedge clk) begin
    logic [33:0] e;
    #2;
    if (prevRst) begin
      checkOutput("reset_state", outResult, outSpecial, outInvalid, 32'h0, 1'b0, 1'b0);
      checkBit("reset_out_valid", outValid, 1'b0);
      checkBit("reset_in_ready", inReady, 1'b1);
    end
    if (rst === 1'b1) begin
      expQ.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        checkBit("hold_valid", outValid, 1'b1);
        checkOutput("hold_stable", outResult, outSpecial, outInvalid, heldR, heldS, heldI);
      end
      held = 1'b0;
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got result=%h, expected no output", outResult);
        end else begin
          e = expQ.pop_front();
          checkOutput("scoreboard", outResult, outSpecial, outInvalid, e[33:2], e[1], e[0]);
        end
      end else if (outValid) begin
        held = 1'b1;
        heldR = outResult;
        heldS = outSpecial;
        heldI = outInvalid;
      end
      if (inValid && inReady) expQ.push_back(model(a, b, op));
    end
    prevRst = rst;
  end

  task automatic directed(input string name, input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                          input logic [31:0] expR, input logic expS, input logic expI);
    logic [33:0] m;
    m = model(ia, ib, iop);
    checkOutput({name, "_model"}, m[33:2], m[1], m[0], expR, expS, expI);
    applyStimulus(1'b1, ia, ib, iop, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    checkBit({name, "_valid"}, outValid, 1'b1);
    checkOutput(name, outResult, outSpecial, outInvalid, expR, expS, expI);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; inValid = 1'b0; a = 0; b = 0; op = 0; outReady = 1'b1;
    inValid64 = 1'b0; a64 = 0; b64 = 0; op64 = 0; outReady64 = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    directed("qnan_pair",  32'h7FC00001, 32'h7FC00002, 1'b0, 32'h7FC00002, 1'b1, 1'b0);
    directed("inf_minus",  32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 1'b1, 1'b1);
    directed("inf_plus",   32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    directed("negzero",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b0);
    directed("mixzero",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b0);
    directed("snan_a",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00001, 1'b1, 1'b1);
    directed("normal",     32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    directed("minus_infb", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1, 1'b0);
    directed("zero_sub",   32'h00000000, 32'h80000001, 1'b1, 32'h00000001, 1'b1, 1'b0);

    // Backpressure: four back-to-back pairs while the sink stalls three cycles.
    applyStimulus(1'b1, 32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 32'hC0000000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7FA00000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    #1 checkBit("bp_in_ready_low", inReady, 1'b0);
    applyStimulus(1'b1, 32'h7FA00000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    #1 checkBit("bp_in_ready_high", inReady, 1'b1);
    applyStimulus(1'b1, 32'hFF800000, 32'hFF800000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #3 checkBit("bp_drained", expQ.size() == 0, 1'b1);

    // Reset one cycle after acceptance must drop the pair.
    applyStimulus(1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #3 checkBit("rst_flush_no_valid", outValid, 1'b0);
    end

    // Double-precision instance.
    @(negedge clk);
    inValid64 = 1'b1; a64 = 64'h7FF0000000000000; b64 = 64'h7FF0000000000000; op64 = 1'b1;
    @(negedge clk);
    inValid64 = 1'b0;
    @(negedge clk);
    #3;
    checkBit("dp_valid", outValid64, 1'b1);
    checks++;
    if (outResult64 !== 64'hFFF8000000000000 || outSpecial64 !== 1'b1 || outInvalid64 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dp_inf_minus: got result=%h special=%b invalid=%b, expected result=fff8000000000000 special=1 invalid=1",
               outResult64, outSpecial64, outInvalid64);
    end

    // Random traffic with random backpressure and rare resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end

    guard = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #3;
      guard++;
    end while ((expQ.size() != 0 || outValid) && guard < 20);
    checkBit("final_drain", (expQ.size() == 0) && !outValid, 1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
